dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory of the accumulator pipeline between two requesters:
  - the core MEM stage (data_ptr-driven loads/stores);
  - a host loader/debug port that preloads and inspects data memory.
- The core has default priority. A starvation counter guarantees the host a slot.
- core_stall freezes the pipeline while the core is denied.
- Sits between pipeAcc16's MEM stage and the data_mem macro.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_WAIT, 4, consecutive denied host cycles before the host gets priority (legal range 1..15)

Ports:
- clk1  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core access request
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core access accepted this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rdata  out  DW  read data for the core
- core_rvalid  out  1  core_rdata valid
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rdata  out  DW  read data for the host
- host_rvalid  out  1  host_rdata valid
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  synchronous-read data, valid one cycle after mem_en & ~mem_we

Behaviour:
- Reset (rst_n low, asynchronous): state = CORE_PRI, wait_cnt = 0, rd_owner = NONE, core_rvalid = host_rvalid = 0. Combinational outputs follow from req inputs = 0, so all grants and mem_* are 0. A read in flight at reset is discarded; no rvalid after reset is released.
- Grants (combinational from state and requests):
  - CORE_PRI: core_gnt = core_req; host_gnt = host_req & ~core_req.
  - HOST_PRI: host_gnt = host_req; core_gnt = core_req & ~host_req.
  - At most one grant per cycle. No grant without its req.
- Memory mux (combinational):
  - mem_en = core_gnt | host_gnt.
  - mem_we/addr/wdata are taken from the granted requester.
  - When nothing is granted, mem_we/addr/wdata = 0.
- Read return:
  - Registered rd_owner = CORE, HOST or NONE, set from a granted read.
  - The cycle after a granted read, the owner's rvalid = 1.
  - core_rdata = host_rdata = mem_rdata, gated to 0 when the corresponding rvalid = 0.
  - Writes produce no rvalid. Read latency is exactly 1 cycle. Back-to-back reads give 1 result per cycle.
- Starvation counter wait_cnt (4 bit):
  - Increments each cycle host_req & ~host_gnt.
  - Clears on host_gnt or ~host_req.
- FSM transitions:
  - CORE_PRI → HOST_PRI when the host is denied and wait_cnt == MAX_WAIT-1. wait_cnt clears on this transition.
  - HOST_PRI → CORE_PRI on host_gnt, or when host_req drops.
  - Net effect: with both requesting continuously, the host gets exactly 1 grant in every MAX_WAIT+1 cycles.
- Ordering: accesses complete in grant order; write-then-read to the same address by different owners in consecutive cycles returns the new data.
- core_stall is combinational. The pipeline must hold MEM-stage signals stable while core_stall = 1.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t {CORE_PRI, HOST_PRI}
  - owner_t {NONE, CORE, HOST}
  - default AW/DW constants
- One natural sub-module: arb_wait_ctr (saturating starvation counter with a threshold flag). Everything else stays in dmem_arbiter.

Test Plan:
- Reset: hold rst_n = 0 with core_req = host_req = 1 → all grants, mem_en and rvalids read 0. Deassert rst_n → core granted on the first edge.
- Core-only read: core reads addr 0x0001 with mem holding 0x0002 → mem_en = 1, mem_addr = 0x0001 that cycle. Next cycle core_rvalid = 1, core_rdata = 0x0002, core_stall = 0 throughout.
- Contention/starvation, MAX_WAIT = 4: both request continuously for 10 cycles → host_gnt only in cycles 5 and 10; core_stall = 1 exactly in those cycles.
- Host preload then core read: host writes 0x0003 to addr 2, core reads addr 2 in the next cycle → core_rdata = 0x0003, host_rvalid never asserted.
- Interleaved reads: core reads addr 1, host reads addr 0 in the following cycle → core_rvalid then host_rvalid in successive cycles, each with its own data and no cross-delivery.
- Reset mid-read: assert rst_n low in the cycle after a granted host read → host_rvalid stays 0, state returns to CORE_PRI, wait_cnt = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  typedef enum logic {CORE_PRI, HOST_PRI} arb_state_t;
  typedef enum logic [1:0] {NONE, CORE, HOST} owner_t;
endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr: saturating host starvation counter with a threshold flag
module arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_thr_o
);
  logic [3:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? 4'd0 : (inc_i && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
  assign at_thr_o = cnt_q == 4'(MAX_WAIT - 1);
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage and the host port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  arb_state_t state_q, state_d;
  owner_t     rd_owner_q, rd_owner_d;
  logic       at_thr, go_host;
  // grants are masked while rst_n is low so held requests cannot reach memory
  assign core_gnt   = rst_n & core_req & ((state_q == CORE_PRI) | ~host_req);
  assign host_gnt   = rst_n & host_req & ((state_q == HOST_PRI) | ~core_req);
  assign core_stall = core_req & ~core_gnt;
  assign go_host    = (state_q == CORE_PRI) & host_req & ~host_gnt & at_thr;
  arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .inc_i   (host_req & ~host_gnt),
    .clr_i   (host_gnt | ~host_req | go_host),
    .at_thr_o(at_thr)
  );
  always_comb begin
    state_d = state_q;
    if (state_q == CORE_PRI) state_d = go_host ? HOST_PRI : CORE_PRI;
    else state_d = (host_gnt | ~host_req) ? CORE_PRI : HOST_PRI;
    rd_owner_d = (core_gnt & ~core_we) ? CORE : (host_gnt & ~host_we) ? HOST : NONE;
  end
  assign mem_en    = core_gnt | host_gnt;
  assign mem_we    = core_gnt ? core_we : host_gnt & host_we;
  assign mem_addr  = core_gnt ? core_addr : host_gnt ? host_addr : '0;
  assign mem_wdata = core_gnt ? core_wdata : host_gnt ? host_wdata : '0;
  assign core_rvalid = rd_owner_q == CORE;
  assign host_rvalid = rd_owner_q == HOST;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CORE_PRI;
      rd_owner_q <= NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule
